avalon_pio_bidir: RTL and testbench

- Parametrised Avalon-MM slave PIO; next generation of the team's fixed 4-bit output-only PIO (e.g. the inference-result port).
- Adds per-bit direction, input synchronisation, edge capture, interrupt masking and atomic set/clear writes.
- Sits between the Nios II Avalon fabric and FPGA-side logic or pins (result LEDs, button/switch inputs, done flags).

---
 rtl/avalon_pio_pkg.sv | 20 ++
 rtl/avalon_pio_bidir_if.sv | 21 ++
 rtl/pio_edge_detect.sv | 46 ++++
 rtl/avalon_pio_bidir.sv | 106 ++++++++++
 tb/tb_avalon_pio_bidir.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_pio_pkg.sv
// Shared constants for the bidirectional Avalon-MM PIO: register offsets and edge senses.
package avalon_pio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned BUS_W  = 32;

    // Word offsets of the register map
    localparam logic [ADDR_W-1:0] PIO_DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] PIO_DIR     = 3'd1;
    localparam logic [ADDR_W-1:0] PIO_IRQMASK = 3'd2;
    localparam logic [ADDR_W-1:0] PIO_EDGECAP = 3'd3;
    localparam logic [ADDR_W-1:0] PIO_OUTSET  = 3'd4;
    localparam logic [ADDR_W-1:0] PIO_OUTCLR  = 3'd5;

    // Edge capture sense selection
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage : avalon_pio_pkg

// File: rtl/avalon_pio_bidir_if.sv
// Avalon-MM slave bus bundle for the PIO register port.
interface avalon_pio_bidir_if;
    import avalon_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface : avalon_pio_bidir_if

// File: rtl/pio_edge_detect.sv
// Input path: two-flop synchroniser, history flop and per-bit edge pulse.
module pio_edge_detect
    import avalon_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned EDGE_TYPE  = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic [DATA_WIDTH-1:0] in_sync_o,
    output logic [DATA_WIDTH-1:0] edge_pulse_o
);

    logic [DATA_WIDTH-1:0] meta_q;
    logic [DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] prev_q;

    // Synchronise the asynchronous pins and keep one cycle of history
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= in_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Edge pulse selected by the configured sense
    always_comb begin
        edge_pulse_o = '0;
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_pulse_o = sync_q & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edge_pulse_o = ~sync_q & prev_q;
        end else begin
            edge_pulse_o = sync_q ^ prev_q;
        end
    end

    assign in_sync_o = sync_q;

endmodule : pio_edge_detect

// File: rtl/avalon_pio_bidir.sv
// Bidirectional Avalon-MM PIO: register file, read mux and level interrupt.
module avalon_pio_bidir
    import avalon_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter logic [31:0] RESET_DIR   = 32'h0,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned IRQ_EN      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avalon_pio_bidir_if.slave     bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] out_en,
    output logic                  irq
);

    localparam logic [DATA_WIDTH-1:0] RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] RST_DIR  = RESET_DIR[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] cap_clr;
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] edge_pulse;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  wr;

    pio_edge_detect #(
        .DATA_WIDTH (DATA_WIDTH),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_edge (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_i         (in_port),
        .in_sync_o    (in_sync),
        .edge_pulse_o (edge_pulse)
    );

    // Upper write-data bits are deliberately discarded
    if (DATA_WIDTH < BUS_W) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^bus.writedata[BUS_W-1:DATA_WIDTH];
    end

    assign wr    = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[DATA_WIDTH-1:0];

    // Next-state decode for the register file; a fresh edge beats a W1C clear
    always_comb begin
        data_d  = data_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr) begin
            case (bus.address)
                PIO_DATA:    data_d  = wdata;
                PIO_DIR:     dir_d   = wdata;
                PIO_IRQMASK: if (IRQ_EN != 0) mask_d = wdata;
                PIO_EDGECAP: cap_clr = wdata;
                PIO_OUTSET:  data_d  = data_q | wdata;
                PIO_OUTCLR:  data_d  = data_q & ~wdata;
                default:     ;
            endcase
        end
        cap_d = (cap_q & ~cap_clr) | (edge_pulse & ~dir_q);
    end

    // Register file state with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= RST_DATA;
            dir_q  <= RST_DIR;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    // Zero-wait-state read mux; output bits read back the driven value
    always_comb begin
        rd_val = '0;
        case (bus.address)
            PIO_DATA:    rd_val = (dir_q & data_q) | (~dir_q & in_sync);
            PIO_DIR:     rd_val = dir_q;
            PIO_IRQMASK: rd_val = (IRQ_EN != 0) ? mask_q : '0;
            PIO_EDGECAP: rd_val = cap_q;
            default:     rd_val = '0;
        endcase
    end

    assign bus.readdata = bus.chipselect ? BUS_W'(rd_val) : '0;
    assign out_port     = data_q;
    assign out_en       = dir_q;
    assign irq          = (IRQ_EN != 0) && ((cap_q & mask_q) != '0);

endmodule : avalon_pio_bidir

// File: tb/tb_avalon_pio_bidir.sv
// Scoreboard bench for avalon_pio_bidir (4 bits, reset data 0xA, reset dir 0xF, rising edges).
module tb_avalon_pio_bidir;

    typedef struct {
        logic [31:0] rd;
        logic        pins;
        logic [3:0]  out;
        logic [3:0]  en;
        logic        irq;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_port;
    logic [3:0] out_port;
    logic [3:0] out_en;
    logic       irq;
    logic       done = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    avalon_pio_bidir_if bus ();

    avalon_pio_bidir #(
        .DATA_WIDTH  (4),
        .RESET_VALUE (32'hA),
        .RESET_DIR   (32'hF),
        .EDGE_TYPE   (0),
        .IRQ_EN      (1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .out_en   (out_en),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // One idle cycle; entered and left 1 time unit after a rising edge
    task automatic idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rdp(input logic [2:0] a, input logic [31:0] e, input logic p,
                       input logic [3:0] o, input logic [3:0] en, input logic q,
                       input string tag);
        exp_t x;
        x.rd = e; x.pins = p; x.out = o; x.en = en; x.irq = q; x.tag = tag;
        exp_q.push_back(x);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
        rdp(a, e, 1'b0, 4'h0, 4'h0, 1'b0, tag);
    endtask

    // Stimulus driver
    initial begin
        reset_n        = 1'b0;
        in_port        = 4'h0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        rdp(3'd0, 32'h0000000A, 1'b1, 4'hA, 4'hF, 1'b0, "reset_data");
        rd(3'd2, 32'h0, "reset_mask");
        rd(3'd3, 32'h0, "reset_cap");

        // DATA / OUTSET / OUTCLR
        wr(3'd0, 32'hFFFFFFF5);
        rdp(3'd0, 32'h5, 1'b1, 4'h5, 4'hF, 1'b0, "data_wr");
        wr(3'd4, 32'h2);
        rdp(3'd4, 32'h0, 1'b1, 4'h7, 4'hF, 1'b0, "outset");
        wr(3'd5, 32'h4);
        rdp(3'd5, 32'h0, 1'b1, 4'h3, 4'hF, 1'b0, "outclr");
        rd(3'd0, 32'h3, "data_after_setclr");

        // Rising edge on bit0: capture and irq exactly three edges later
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h1);
        rd(3'd1, 32'h0, "dir_rb");
        rd(3'd2, 32'h1, "mask_rb");
        in_port = 4'h1;
        rdp(3'd3, 32'h0, 1'b1, 4'h3, 4'h0, 1'b0, "cap_lat0");
        rdp(3'd3, 32'h0, 1'b1, 4'h3, 4'h0, 1'b0, "cap_lat1");
        rdp(3'd3, 32'h0, 1'b1, 4'h3, 4'h0, 1'b0, "cap_lat2");
        rdp(3'd3, 32'h1, 1'b1, 4'h3, 4'h0, 1'b1, "cap_lat3");
        wr(3'd3, 32'h1);
        rdp(3'd3, 32'h0, 1'b1, 4'h3, 4'h0, 1'b0, "w1c_clear");

        // New edge coinciding with W1C clear keeps the bit set
        in_port = 4'h0;
        idle(); idle(); idle();
        in_port = 4'h1;
        idle(); idle(); idle();
        rdp(3'd3, 32'h1, 1'b1, 4'h3, 4'h0, 1'b1, "cap_pre_race");
        in_port = 4'h0;
        idle(); idle(); idle();
        in_port = 4'h1;
        idle(); idle();
        wr(3'd3, 32'h1);
        rdp(3'd3, 32'h1, 1'b1, 4'h3, 4'h0, 1'b1, "race_edge_wins");
        rdp(3'd3, 32'h1, 1'b1, 4'h3, 4'h0, 1'b1, "race_hold");

        // Output bits never capture; DATA read mixes data_out and in_sync
        wr(3'd3, 32'hF);
        rdp(3'd3, 32'h0, 1'b1, 4'h3, 4'h0, 1'b0, "clear_all");
        wr(3'd1, 32'h1);
        in_port = 4'h0;
        idle(); idle(); idle(); idle();
        rd(3'd3, 32'h0, "out_bit_fall");
        in_port = 4'h1;
        idle(); idle(); idle(); idle();
        rd(3'd3, 32'h0, "out_bit_rise");
        in_port = 4'hA;
        idle(); idle(); idle();
        rdp(3'd0, 32'hB, 1'b1, 4'h3, 4'h1, 1'b0, "data_mixed");
        rdp(3'd3, 32'hA, 1'b1, 4'h3, 4'h1, 1'b0, "cap_masked");

        // Build EDGECAP=F with irq high, then reset with a coincident write
        wr(3'd1, 32'h0);
        wr(3'd2, 32'hF);
        in_port = 4'h0;
        idle(); idle(); idle();
        in_port = 4'hF;
        idle(); idle(); idle();
        rdp(3'd3, 32'hF, 1'b1, 4'h3, 4'h0, 1'b1, "cap_all");
        reset_n = 1'b0;
        wr(3'd0, 32'h5);
        reset_n = 1'b1;
        rdp(3'd0, 32'hA, 1'b1, 4'hA, 4'hF, 1'b0, "rst_mid_data");
        rd(3'd1, 32'hF, "rst_mid_dir");
        rd(3'd2, 32'h0, "rst_mid_mask");
        rd(3'd3, 32'h0, "rst_mid_cap");

        // Reserved offsets
        wr(3'd6, 32'hF);
        wr(3'd7, 32'hF);
        rd(3'd6, 32'h0, "rsvd6");
        rd(3'd7, 32'h0, "rsvd7");
        rdp(3'd0, 32'hA, 1'b1, 4'hA, 4'hF, 1'b0, "rsvd_data");
        rd(3'd1, 32'hF, "rsvd_dir");
        rd(3'd2, 32'h0, "rsvd_mask");
        rd(3'd3, 32'h0, "rsvd_cap");

        idle();
        done = 1'b1;
    end

    // Monitor: compares every read cycle against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (bus.chipselect && bus.write_n) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: addr %0d readdata %h, no expectation queued",
                             bus.address, bus.readdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.readdata !== e.rd) begin
                        errors++;
                        $display("FAIL %s: readdata got %h want %h", e.tag, bus.readdata, e.rd);
                    end
                    if (e.pins) begin
                        checks++;
                        if ({out_port, out_en, irq} !== {e.out, e.en, e.irq}) begin
                            errors++;
                            $display("FAIL %s_pins: out_port/out_en/irq got %h/%h/%b want %h/%h/%b",
                                     e.tag, out_port, out_en, irq, e.out, e.en, e.irq);
                        end
                    end
                end
            end else if (!bus.chipselect) begin
                checks++;
                if (bus.readdata !== 32'h0) begin
                    errors++;
                    $display("FAIL deselected_readdata: got %h want 00000000", bus.readdata);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule : tb_avalon_pio_bidir
